// File: rtl/mor1kx_spr_sys_group_pkg.sv
// -----------------------------------------------------------------------------
// mor1kx_spr_sys_group_pkg
//   Shared constants for the system SPR group block: SPR group number, the
//   group-0 index map, the last read-only index, and the access FSM states.
// -----------------------------------------------------------------------------
package mor1kx_spr_sys_group_pkg;

   localparam logic [4:0]  SPR_GROUP_SYS      = 5'd0;

   localparam logic [10:0] SPR_IDX_VR         = 11'd0;
   localparam logic [10:0] SPR_IDX_UPR        = 11'd1;
   localparam logic [10:0] SPR_IDX_CPUCFGR    = 11'd2;
   localparam logic [10:0] SPR_IDX_DMMUCFGR   = 11'd3;
   localparam logic [10:0] SPR_IDX_IMMUCFGR   = 11'd4;
   localparam logic [10:0] SPR_IDX_DCCFGR     = 11'd5;
   localparam logic [10:0] SPR_IDX_ICCFGR     = 11'd6;
   localparam logic [10:0] SPR_IDX_DCFGR      = 11'd7;
   localparam logic [10:0] SPR_IDX_PCCFGR     = 11'd8;
   localparam logic [10:0] SPR_IDX_VR2        = 11'd9;
   localparam logic [10:0] SPR_IDX_AVR        = 11'd10;
   localparam logic [10:0] SPR_IDX_EVBAR      = 11'd11;

   // Everything at or below this index is a read-only configuration register.
   localparam logic [10:0] SPR_IDX_LAST_RO    = SPR_IDX_AVR;

   // EVBAR keeps only bits [31:13]; the low bits are hard zero.
   localparam int          EVBAR_LSB          = 13;
   localparam int          EVBAR_W            = 32 - EVBAR_LSB;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_DRAIN = 2'd2
   } sys_state_t;

   function automatic logic is_sys_group(input logic [15:0] addr);
      return addr[15:11] == SPR_GROUP_SYS;
   endfunction

endpackage

// File: rtl/mor1kx_spr_sys_group.sv
// -----------------------------------------------------------------------------
// mor1kx_spr_sys_group
//   System SPR group (group 0) access block. Serves reads of the static
//   configuration registers, VR2 with the pipeline id spliced in, and the
//   writable EVBAR. Each strobe gets exactly one ack; a held strobe is drained
//   before the next access can start.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for a group-0 strobe; access is performed on capture
//   ST_ACK   | ack (and err on illegal write) presented for this one cycle
//   ST_DRAIN | waiting for the master to drop stb before accepting another
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   spr_stb_i/we_i      access request (held until ack) and direction
//   spr_addr_i/dat_i    SPR address {group[4:0], index[10:0]}, write data
//   supervisor_i        current SR[SM]; user-mode writes are rejected
//   spr_vr .. spr_avr   static configuration register values
//   spr_ack_o           one-cycle access-complete pulse
//   spr_dat_o           registered read data, held between reads
//   spr_access_err_o    pulses with ack on an illegal write
//   spr_evbar_o         current exception vector base address
// -----------------------------------------------------------------------------
module mor1kx_spr_sys_group
   import mor1kx_spr_sys_group_pkg::*;
#(
   parameter string       FEATURE_EVBAR      = "NONE",
   parameter logic [7:0]  OPTION_PIPELINE_ID = 8'd0,
   parameter logic [31:0] OPTION_RESET_PC    = 32'h100
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        spr_stb_i,
   input  logic        spr_we_i,
   input  logic [15:0] spr_addr_i,
   input  logic [31:0] spr_dat_i,
   input  logic        supervisor_i,

   input  logic [31:0] spr_vr,
   input  logic [31:0] spr_vr2,
   input  logic [31:0] spr_upr,
   input  logic [31:0] spr_cpucfgr,
   input  logic [31:0] spr_dmmucfgr,
   input  logic [31:0] spr_immucfgr,
   input  logic [31:0] spr_dccfgr,
   input  logic [31:0] spr_iccfgr,
   input  logic [31:0] spr_dcfgr,
   input  logic [31:0] spr_pccfgr,
   input  logic [31:0] spr_avr,

   output logic        spr_ack_o,
   output logic [31:0] spr_dat_o,
   output logic        spr_access_err_o,
   output logic [31:0] spr_evbar_o
);

   localparam bit                 EVBAR_EN  = (FEATURE_EVBAR != "NONE");
   localparam logic [EVBAR_W-1:0] EVBAR_RST = EVBAR_EN ?
                                              OPTION_RESET_PC[31:EVBAR_LSB] :
                                              '0;

   sys_state_t         r_state;
   sys_state_t         w_state_nxt;
   logic               w_capture;

   logic               r_ack;
   logic               r_err;
   logic [31:0]        r_dat;
   logic [EVBAR_W-1:0] r_evbar;

   logic               w_sys_group;
   logic [10:0]        w_idx;
   logic [31:0]        w_rd_data;
   logic               w_wr_err;
   logic               w_evbar_wr;
   logic               w_unused;

   assign w_sys_group = is_sys_group(spr_addr_i);
   assign w_idx       = spr_addr_i[10:0];

   // VR2 low byte is replaced by the pipeline id; EVBAR low bits never stored.
   assign w_unused    = ^{spr_vr2[7:0], spr_dat_i[EVBAR_LSB-1:0]};

   // -------------------------------------------------------------------------
   // Access FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (spr_stb_i && w_sys_group) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!spr_stb_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Read mux
   // -------------------------------------------------------------------------
   always_comb begin
      w_rd_data = 32'd0;
      case (w_idx)
         SPR_IDX_VR:       w_rd_data = spr_vr;
         SPR_IDX_UPR:      w_rd_data = spr_upr;
         SPR_IDX_CPUCFGR:  w_rd_data = spr_cpucfgr;
         SPR_IDX_DMMUCFGR: w_rd_data = spr_dmmucfgr;
         SPR_IDX_IMMUCFGR: w_rd_data = spr_immucfgr;
         SPR_IDX_DCCFGR:   w_rd_data = spr_dccfgr;
         SPR_IDX_ICCFGR:   w_rd_data = spr_iccfgr;
         SPR_IDX_DCFGR:    w_rd_data = spr_dcfgr;
         SPR_IDX_PCCFGR:   w_rd_data = spr_pccfgr;
         SPR_IDX_VR2:      w_rd_data = {spr_vr2[31:8], OPTION_PIPELINE_ID};
         SPR_IDX_AVR:      w_rd_data = spr_avr;
         SPR_IDX_EVBAR:    w_rd_data = spr_evbar_o;
         default:          w_rd_data = 32'd0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Write qualification
   //   Writes to the configuration registers and any user-mode write are
   //   acked and flagged. Writes past EVBAR land on nothing and are not
   //   flagged, mirroring the quiet zero returned for reads there.
   // -------------------------------------------------------------------------
   assign w_wr_err   = !supervisor_i || (w_idx <= SPR_IDX_LAST_RO);
   assign w_evbar_wr = EVBAR_EN && supervisor_i && (w_idx == SPR_IDX_EVBAR);

   // The whole access is carried out on the capture edge, so ack, data and
   // the EVBAR update all become visible together in the ACK cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= 32'd0;
         r_evbar <= EVBAR_RST;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         if (w_capture) begin
            r_ack <= 1'b1;
            if (spr_we_i) begin
               r_err <= w_wr_err;
               if (w_evbar_wr) begin
                  r_evbar <= spr_dat_i[31:EVBAR_LSB];
               end
            end else begin
               r_dat <= w_rd_data;
            end
         end
      end
   end

   assign spr_ack_o        = r_ack;
   assign spr_access_err_o = r_err;
   assign spr_dat_o        = r_dat;
   assign spr_evbar_o      = {r_evbar, {EVBAR_LSB{1'b0}}};

endmodule

// File: tb/tb_mor1kx_spr_sys_group.sv
module tb_mor1kx_spr_sys_group;

   localparam logic [7:0] PIPE_ID = 8'h05;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        spr_stb_i = 1'b0;
   logic        spr_we_i = 1'b0;
   logic [15:0] spr_addr_i = 16'd0;
   logic [31:0] spr_dat_i = 32'd0;
   logic        supervisor_i = 1'b0;
   logic [31:0] cfg [0:10];
   logic        spr_ack_o;
   logic [31:0] spr_dat_o;
   logic        spr_access_err_o;
   logic [31:0] spr_evbar_o;

   always #5 clk = ~clk;

   mor1kx_spr_sys_group #(
      .FEATURE_EVBAR      ("ENABLED"),
      .OPTION_PIPELINE_ID (PIPE_ID),
      .OPTION_RESET_PC    (32'h100)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .spr_stb_i        (spr_stb_i),
      .spr_we_i         (spr_we_i),
      .spr_addr_i       (spr_addr_i),
      .spr_dat_i        (spr_dat_i),
      .supervisor_i     (supervisor_i),
      .spr_vr           (cfg[0]),
      .spr_vr2          (cfg[9]),
      .spr_upr          (cfg[1]),
      .spr_cpucfgr      (cfg[2]),
      .spr_dmmucfgr     (cfg[3]),
      .spr_immucfgr     (cfg[4]),
      .spr_dccfgr       (cfg[5]),
      .spr_iccfgr       (cfg[6]),
      .spr_dcfgr        (cfg[7]),
      .spr_pccfgr       (cfg[8]),
      .spr_avr          (cfg[10]),
      .spr_ack_o        (spr_ack_o),
      .spr_dat_o        (spr_dat_o),
      .spr_access_err_o (spr_access_err_o),
      .spr_evbar_o      (spr_evbar_o)
   );

   typedef struct {
      logic [31:0] dat;
      logic        err;
      logic [31:0] evbar;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Reference state: architectural EVBAR and the last value a read returned.
   // EVBAR reset value is OPTION_RESET_PC with the low 13 bits cleared (0x100 -> 0).
   logic [31:0] m_evbar = 32'h0;
   logic [31:0] m_last_dat = 32'h0;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %08h want %08h", name, got, want);
      end
   endtask

   task automatic model_reset();
      m_evbar    = 32'h100 & 32'hFFFF_E000;
      m_last_dat = 32'h0;
   endtask

   task automatic model_txn(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                            input logic sup, output exp_t e);
      int idx;
      idx = int'(addr[10:0]);
      if (we) begin
         e.err = !sup || (idx <= 10);
         if (sup && idx == 11) m_evbar = dat & 32'hFFFF_E000;
         e.dat = m_last_dat;
      end else begin
         e.err = 1'b0;
         if (idx == 9)       e.dat = (cfg[9] & 32'hFFFF_FF00) | {24'h0, PIPE_ID};
         else if (idx <= 10) e.dat = cfg[idx];
         else if (idx == 11) e.dat = m_evbar;
         else                e.dat = 32'h0;
         m_last_dat = e.dat;
      end
      e.evbar = m_evbar;
   endtask

   task automatic start_txn(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                            input logic sup);
      exp_t e;
      model_txn(we, addr, dat, sup, e);
      sb_q.push_back(e);
      spr_we_i     = we;
      spr_addr_i   = addr;
      spr_dat_i    = dat;
      supervisor_i = sup;
      spr_stb_i    = 1'b1;
   endtask

   // Wait for the ack, keep stb up for `hold` more cycles while scrambling the
   // request fields, then drop stb for `low` cycles.
   task automatic finish_txn(input int hold, input int low);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         seen = spr_ack_o;
      end
      n_checks++;
      if (!seen || lat != 1) begin
         n_errors++;
         $display("FAIL ack_latency: got %0d cycles (seen=%0d) want 1", lat, seen);
      end
      for (int i = 0; i < hold; i++) begin
         spr_addr_i   = 16'($urandom_range(0, 11));
         spr_we_i     = 1'($urandom);
         spr_dat_i    = $urandom;
         supervisor_i = 1'($urandom);
         @(negedge clk);
      end
      spr_stb_i = 1'b0;
      for (int i = 0; i < low; i++) @(negedge clk);
   endtask

   // Monitor: every ack consumes exactly one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst && spr_access_err_o && !spr_ack_o) begin
         n_errors++;
         $display("FAIL err_without_ack: got err=1 ack=0 want err=0");
      end
      if (rst && spr_ack_o) begin
         if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_ack: got ack with empty queue want no ack");
         end else begin
            e = sb_q.pop_front();
            check32("ack_dat", spr_dat_o, e.dat);
            check32("ack_err", {31'd0, spr_access_err_o}, {31'd0, e.err});
            check32("ack_evbar", spr_evbar_o, e.evbar);
         end
      end
   end

   initial begin
      int idx;
      logic we, sup;
      for (int i = 0; i <= 10; i++) cfg[i] = $urandom;
      cfg[9] = 32'h0001_0100;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check32("rst_ack", {31'd0, spr_ack_o}, 32'd0);
      check32("rst_err", {31'd0, spr_access_err_o}, 32'd0);
      check32("rst_dat", spr_dat_o, 32'd0);
      check32("rst_evbar", spr_evbar_o, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // VR2 read with pipeline id
      start_txn(1'b0, 16'd9, 32'h0, 1'b0);
      finish_txn(1, 1);
      check32("vr2_const", spr_dat_o, 32'h0001_0105);

      // User-mode EVBAR write rejected
      start_txn(1'b1, 16'd11, 32'hFFFF_FFFF, 1'b0);
      finish_txn(2, 1);
      check32("evbar_user_const", spr_evbar_o, 32'h0);

      // Supervisor EVBAR write, then read back
      start_txn(1'b1, 16'd11, 32'hDEAD_BEEF, 1'b1);
      finish_txn(1, 2);
      start_txn(1'b0, 16'd11, 32'h0, 1'b0);
      finish_txn(1, 1);
      check32("evbar_read_const", spr_dat_o, 32'hDEAD_A000);
      check32("evbar_out_const", spr_evbar_o, 32'hDEAD_A000);

      // Read-only write by supervisor: err, data held
      start_txn(1'b1, 16'd3, 32'h1234_5678, 1'b1);
      finish_txn(1, 1);

      // stb held for 5 cycles: one ack, second only after re-assertion
      start_txn(1'b0, 16'd1, 32'h0, 1'b1);
      finish_txn(4, 1);
      start_txn(1'b0, 16'd1, 32'h0, 1'b1);
      finish_txn(1, 1);

      // Foreign group is ignored
      spr_addr_i = 16'h0801;
      spr_we_i   = 1'b0;
      spr_stb_i  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check32("grp1_no_ack", {31'd0, spr_ack_o}, 32'd0);
      end
      spr_stb_i = 1'b0;
      @(negedge clk);

      // Unmapped group-0 index reads zero without error
      start_txn(1'b0, 16'd50, 32'h0, 1'b0);
      finish_txn(1, 1);
      check32("unmapped_const", spr_dat_o, 32'h0);

      // Reset asserted in the ACK cycle
      spr_addr_i = 16'd1;
      spr_we_i   = 1'b0;
      spr_stb_i  = 1'b1;
      @(posedge clk);
      #2;
      check32("ack_before_rst", {31'd0, spr_ack_o}, 32'd1);
      rst = 1'b0;
      #1;
      check32("ack_dropped_rst", {31'd0, spr_ack_o}, 32'd0);
      check32("evbar_after_rst", spr_evbar_o, 32'h0);
      model_reset();
      @(negedge clk);
      begin
         exp_t e;
         model_txn(1'b0, 16'd1, 32'h0, 1'b0, e);
         sb_q.push_back(e);
      end
      rst = 1'b1;
      finish_txn(1, 1);

      // Randomised traffic
      for (int n = 0; n < 200; n++) begin
         we  = 1'($urandom);
         sup = 1'($urandom);
         if (!we && ($urandom_range(0, 7) == 0)) idx = $urandom_range(12, 2047);
         else if ($urandom_range(0, 2) == 0)     idx = 11;
         else                                    idx = $urandom_range(0, 10);
         start_txn(we, 16'(idx), $urandom, sup);
         finish_txn($urandom_range(1, 3), $urandom_range(1, 2));
      end

      repeat (5) @(negedge clk);
      check32("queue_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
